mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 38 +++
 rtl/mem_arbiter_if.sv | 70 +++++++
 rtl/mem_arb_pick.sv | 35 +++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, grant codes,
// bus widths and the wait-counter limits.
package mem_arbiter_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int STATE_W = 2;
  localparam int GRANT_W = 2;
  localparam int CNT_W   = 4;

  // Largest number of extra SRAM cycles the wait counter can hold.
  localparam int unsigned WAIT_MAX = 15;

  // FSM state encoding. Kept as plain constants so older code can compare
  // against raw values.
  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_ACCESS = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE   = 2'd2;

  // Owner codes, as seen on the grant output.
  localparam logic [GRANT_W-1:0] GNT_NONE = 2'd0;
  localparam logic [GRANT_W-1:0] GNT_BOOT = 2'd1;
  localparam logic [GRANT_W-1:0] GNT_JTAG = 2'd2;
  localparam logic [GRANT_W-1:0] GNT_CORE = 2'd3;

  typedef logic [GRANT_W-1:0] grant_t;
  typedef logic [STATE_W-1:0] state_t;

  // Wait counter load value. Out-of-range settings saturate at WAIT_MAX so a
  // bad parameter cannot wrap into a short access.
  function automatic logic [CNT_W-1:0] clampWait(input int unsigned cycles);
    if (cycles > WAIT_MAX) begin
      return CNT_W'(WAIT_MAX);
    end
    return CNT_W'(cycles);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes, uP status and SRAM bus for the memory
// arbiter.
//
// Handshake: a requester raises its req together with addr/wr/data and holds
// them until it sees its ack. The arbiter samples the request only in IDLE;
// once granted, the request and its payload are latched, so later changes
// (including dropping req) do not affect the transfer. Ack is a single-cycle
// pulse marking completion; read data is on rdData from that cycle on.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // Requesters
  logic              i_bootReq;
  logic              i_jtagReq;
  logic              i_coreReq;
  logic [ADDR_W-1:0] i_bootAddr;
  logic [ADDR_W-1:0] i_jtagAddr;
  logic [ADDR_W-1:0] i_coreAddr;
  logic              i_jtagWr;
  logic              i_coreWr;
  logic [DATA_W-1:0] i_bootData;
  logic [DATA_W-1:0] i_jtagData;
  logic [DATA_W-1:0] i_coreData;
  logic              o_bootAck;
  logic              o_jtagAck;
  logic              o_coreAck;
  logic [DATA_W-1:0] o_rdData;

  // uP status
  logic              i_smIsBooted;
  logic              i_smIsPaused;

  // SRAM bus
  logic [ADDR_W-1:0] o_memAddr;
  logic              o_memWr;
  logic              o_memEn;
  logic [DATA_W-1:0] o_memDataOut;
  logic              o_memDataOe;
  logic [DATA_W-1:0] i_memDataIn;

  // Current owner
  logic [GRANT_W-1:0] o_grant;

  // Arbiter side
  modport slave (
    input  i_bootReq, i_jtagReq, i_coreReq,
    input  i_bootAddr, i_jtagAddr, i_coreAddr,
    input  i_jtagWr, i_coreWr,
    input  i_bootData, i_jtagData, i_coreData,
    input  i_smIsBooted, i_smIsPaused,
    input  i_memDataIn,
    output o_bootAck, o_jtagAck, o_coreAck, o_rdData,
    output o_memAddr, o_memWr, o_memEn, o_memDataOut, o_memDataOe,
    output o_grant
  );

  // Requester / memory side
  modport master (
    output i_bootReq, i_jtagReq, i_coreReq,
    output i_bootAddr, i_jtagAddr, i_coreAddr,
    output i_jtagWr, i_coreWr,
    output i_bootData, i_jtagData, i_coreData,
    output i_smIsBooted, i_smIsPaused,
    output i_memDataIn,
    input  o_bootAck, o_jtagAck, o_coreAck, o_rdData,
    input  o_memAddr, o_memWr, o_memEn, o_memDataOut, o_memDataOe,
    input  o_grant
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational eligibility filter and fixed-priority selection.
// Boot may only use memory before the uP has booted; JTAG before boot or while
// the uP is paused; the core only while it is booted and running.
// Priority among eligible requesters is boot > jtag > core.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   i_bootReq,
  input  logic   i_jtagReq,
  input  logic   i_coreReq,
  input  logic   i_smIsBooted,
  input  logic   i_smIsPaused,
  output grant_t o_grant
);

  logic bootElig;
  logic jtagElig;
  logic coreElig;

  // Mask requests by uP state, then pick the highest-priority survivor.
  always_comb begin
    bootElig = i_bootReq && !i_smIsBooted;
    jtagElig = i_jtagReq && (!i_smIsBooted || i_smIsPaused);
    coreElig = i_coreReq && i_smIsBooted && !i_smIsPaused;
    o_grant  = GNT_NONE;
    if (bootElig) begin
      o_grant = GNT_BOOT;
    end else if (jtagElig) begin
      o_grant = GNT_JTAG;
    end else if (coreElig) begin
      o_grant = GNT_CORE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way SRAM arbiter for boot loader, JTAG and CPU core.
// One transfer at a time: IDLE picks a winner and latches its request,
// ACCESS drives the SRAM for WAIT_CYCLES+1 cycles, DONE pulses the owner's ack
// with the bus idle. Back-to-back transfers therefore repeat every
// WAIT_CYCLES+3 cycles. o_dbgState exposes the FSM state for observation.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1  // extra SRAM cycles, 0..15
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  mem_arbiter_if.slave  bus,
  output state_t        o_dbgState
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = clampWait(WAIT_CYCLES);

  state_t            state;
  logic [CNT_W-1:0]  waitCnt;
  grant_t            grant;
  grant_t            pickGrant;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] dataQ;
  logic              wrQ;
  logic [DATA_W-1:0] rdDataQ;

  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  logic              selWr;
  logic              inAccess;
  logic              inDone;
  logic              lastAccess;

  mem_arb_pick u_pick (
    .i_bootReq    (bus.i_bootReq),
    .i_jtagReq    (bus.i_jtagReq),
    .i_coreReq    (bus.i_coreReq),
    .i_smIsBooted (bus.i_smIsBooted),
    .i_smIsPaused (bus.i_smIsPaused),
    .o_grant      (pickGrant)
  );

  // Route the winning requester's address, direction and data to the latch.
  // Boot is write-only, so its direction is fixed.
  always_comb begin
    selAddr = '0;
    selData = '0;
    selWr   = 1'b0;
    case (pickGrant)
      GNT_BOOT: begin
        selAddr = bus.i_bootAddr;
        selData = bus.i_bootData;
        selWr   = 1'b1;
      end
      GNT_JTAG: begin
        selAddr = bus.i_jtagAddr;
        selData = bus.i_jtagData;
        selWr   = bus.i_jtagWr;
      end
      GNT_CORE: begin
        selAddr = bus.i_coreAddr;
        selData = bus.i_coreData;
        selWr   = bus.i_coreWr;
      end
      default: begin
        selAddr = '0;
        selData = '0;
        selWr   = 1'b0;
      end
    endcase
  end

  // Transfer sequencing: arbitrate only in IDLE, count down ACCESS, release
  // ownership when leaving DONE. Requests arriving during DONE wait for IDLE.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state   <= ST_IDLE;
      waitCnt <= '0;
      grant   <= GNT_NONE;
      addrQ   <= '0;
      dataQ   <= '0;
      wrQ     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pickGrant != GNT_NONE) begin
            state   <= ST_ACCESS;
            grant   <= pickGrant;
            addrQ   <= selAddr;
            dataQ   <= selData;
            wrQ     <= selWr;
            waitCnt <= WAIT_LOAD;
          end
        end
        ST_ACCESS: begin
          if (waitCnt == '0) begin
            state <= ST_DONE;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          grant <= GNT_NONE;
        end
        default: begin
          state <= ST_IDLE;
          grant <= GNT_NONE;
        end
      endcase
    end
  end

  assign inAccess   = (state == ST_ACCESS);
  assign inDone     = (state == ST_DONE);
  assign lastAccess = inAccess && (waitCnt == '0);

  // Capture SRAM read data on the last ACCESS edge; writes leave it alone.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rdDataQ <= '0;
    end else if (lastAccess && !wrQ) begin
      rdDataQ <= bus.i_memDataIn;
    end
  end

  // Bus and ack outputs decoded from state; write strobes only in ACCESS.
  always_comb begin
    bus.o_memEn      = inAccess;
    bus.o_memWr      = inAccess && wrQ;
    bus.o_memDataOe  = inAccess && wrQ;
    bus.o_memAddr    = addrQ;
    bus.o_memDataOut = dataQ;
    bus.o_bootAck    = inDone && (grant == GNT_BOOT);
    bus.o_jtagAck    = inDone && (grant == GNT_JTAG);
    bus.o_coreAck    = inDone && (grant == GNT_CORE);
    bus.o_rdData     = rdDataQ;
    bus.o_grant      = grant;
    o_dbgState       = state;
  end

endmodule
